fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the fetch address loaded on reset.
REQ-002 Parameter BUF_DEPTH, default 2, is the number of instruction-buffer entries; only 2 is supported.
REQ-003 Port CLK, input, 1, is the single clock; all state changes on its rising edge.
REQ-004 Port RESET, input, 1, is the synchronous, active-high reset.
REQ-005 Port IMEM_PC, output, 32, is the fetch address driven to INST_MEM.PC.
REQ-006 Port IMEM_INST, input, 32, is INST_MEM.INST_CODE, combinationally valid in the same cycle as IMEM_PC.
REQ-007 Port REDIRECT, input, 1, is the branch/jump taken pulse.
REQ-008 Port REDIRECT_PC, input, 32, is the target address, sampled when REDIRECT=1.
REQ-009 Port ID_VALID, output, 1, flags that the buffer head holds an instruction.
REQ-010 Port ID_READY, input, 1, is decode accepting; a pop occurs when ID_VALID & ID_READY.
REQ-011 Port ID_INST, output, 32, is the head instruction.
REQ-012 Port ID_PC, output, 32, is the head instruction address.
REQ-013 Port FETCH_ERR, output, 1, is the sticky misaligned-redirect flag.

Function
REQ-014 States: RUN and HALT; reset enters RUN.
REQ-015 IMEM_PC shall equal the fetch-PC register directly; no combinational path from any input to IMEM_PC.
REQ-016 Push condition in RUN: no REDIRECT, and (count<2 or pop this cycle); the push writes {IMEM_PC, IMEM_INST} and sets fetch-PC <= fetch-PC+4.
REQ-017 Without a push, fetch-PC shall hold.
REQ-018 PC arithmetic shall be 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-019 ID_VALID shall be 1 iff count>0; ID_INST/ID_PC shall come from registered buffer storage, with one cycle of fetch-to-ID_VALID latency.
REQ-020 Full with simultaneous pop: push and pop both occur, count stays 2, order preserved.
REQ-021 Empty: ID_READY is ignored, and no pop occurs.
REQ-022 REDIRECT=1 with REDIRECT_PC[1:0]==0: the buffer is flushed (count<=0), fetch-PC<=REDIRECT_PC, and there is no push or pop that cycle; priority over all other events.
REQ-023 REDIRECT=1 with REDIRECT_PC[1:0]!=0: the buffer is flushed, FETCH_ERR<=1, state<=HALT, and fetch-PC is held.
REQ-024 HALT: no pushes, no pops, ID_VALID=0, REDIRECT ignored; exit only via RESET.
REQ-025 Buffer read and write pointers shall wrap modulo 2.

Reset
REQ-026 With RESET=1 at a rising edge: fetch-PC<=RESET_PC, count<=0, pointers<=0, FETCH_ERR<=0, state<=RUN.
REQ-027 While RESET=1: IMEM_PC=RESET_PC after the first edge, and ID_VALID=0, ID_INST=0, ID_PC=0.
REQ-028 Reset asserted mid-operation shall discard buffered instructions and any same-cycle REDIRECT.
REQ-029 No push shall occur in a cycle where RESET=1.

Structure
REQ-030 Package fetch_pkg shall hold RESET_PC default, INSTR_W=32, ADDR_W=32, the state encoding (RUN, HALT) and the buffer-entry typedef {pc, inst}.
REQ-031 The buffer shall be sub-module fetch_buf: a 2-entry FIFO with push, pop, flush, count and registered head outputs; fetch_ctrl holds the PC, FSM and error flag.
REQ-032 The block shall instantiate no memory itself; INST_MEM is connected at the top level.

Verification
REQ-033 Reset release, ID_READY=1, memory words 0x00500093, 0x00A00113, 0x002081B3 at addresses 0, 4, 8 -> ID_PC 0, 4, 8 on consecutive cycles after a 1-cycle latency, ID_INST matching each word.
REQ-034 ID_READY=0 for 5 cycles -> count saturates at 2, IMEM_PC holds at 8, ID_PC stays 0; ID_READY=1 -> 0, 4, 8 delivered in order with none lost or duplicated.
REQ-035 REDIRECT=1, REDIRECT_PC=0x40 while full -> next cycle ID_VALID=0 and IMEM_PC=0x40; the following cycle ID_PC=0x40.
REQ-036 REDIRECT_PC=0x42 -> FETCH_ERR=1 and ID_VALID=0 thereafter; a later REDIRECT_PC=0x80 is ignored; RESET -> FETCH_ERR=0 and IMEM_PC=RESET_PC.
REQ-037 Fetch-PC preset near the top via REDIRECT_PC=0xFFFFFFF8 -> ID_PC sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-038 RESET asserted with 2 entries buffered plus a simultaneous REDIRECT -> next cycle count=0 and IMEM_PC=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
// Holds widths, FSM encoding and the buffer entry layout.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] inst;
  } buf_entry_t;
endpackage

// File: rtl/fetch_if.sv
// Fetch-side bus: instruction memory, redirect and decode handshake.
// master is the fetch unit, slave is the surrounding core/memory.
interface fetch_if;
  logic [31:0] IMEM_PC;
  logic [31:0] IMEM_INST;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        ID_VALID;
  logic        ID_READY;
  logic [31:0] ID_INST;
  logic [31:0] ID_PC;
  logic        FETCH_ERR;

  modport master (
    output IMEM_PC, ID_VALID, ID_INST, ID_PC, FETCH_ERR,
    input  IMEM_INST, REDIRECT, REDIRECT_PC, ID_READY
  );

  modport slave (
    input  IMEM_PC, ID_VALID, ID_INST, ID_PC, FETCH_ERR,
    output IMEM_INST, REDIRECT, REDIRECT_PC, ID_READY
  );
endinterface

// File: rtl/fetch_buf.sv
// Two-entry instruction FIFO with flush.
// Head is read straight from registered storage.
import fetch_pkg::*;

module fetch_buf (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_flush,
  input  buf_entry_t i_din,
  output logic [1:0] o_count,
  output buf_entry_t o_head
);
  buf_entry_t r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop)
        r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count
               + {1'b0, i_push}
               - {1'b0, i_pop};
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: PC register, RUN/HALT FSM and sticky error flag.
// Instruction memory sits outside; the buffer is fetch_buf.
import fetch_pkg::*;

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          BUF_DEPTH = 2
) (
  input logic     CLK,
  input logic     RESET,
  fetch_if.master bus
);
  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_err;

  logic        w_run;
  logic        w_misal;
  logic        w_room;
  logic        w_pop;
  logic        w_push;
  logic        w_flush;
  logic [1:0]  w_count;
  buf_entry_t  w_din;
  buf_entry_t  w_head;

  assign w_run   = (r_state == RUN);
  assign w_misal = (bus.REDIRECT_PC[1:0] != 2'b00);
  assign w_room  = (32'(w_count) < BUF_DEPTH);
  assign w_flush = w_run & bus.REDIRECT;
  assign w_pop   = w_run & ~bus.REDIRECT
                 & (w_count != 2'd0) & bus.ID_READY;
  assign w_push  = w_run & ~bus.REDIRECT
                 & (w_room | w_pop);
  assign w_din   = '{pc: r_pc, inst: bus.IMEM_INST};

  fetch_buf u_buf (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   (w_din),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // A misaligned target is fatal: stop fetching until reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (bus.REDIRECT) begin
            if (w_misal) begin
              r_err   <= 1'b1;
              r_state <= HALT;
            end else begin
              r_pc <= bus.REDIRECT_PC;
            end
          end else if (w_push) begin
            r_pc <= r_pc + 32'd4;
          end
        end
        HALT: r_state <= HALT;
        default: r_state <= HALT;
      endcase
    end
  end

  assign bus.IMEM_PC   = r_pc;
  assign bus.ID_VALID  = w_run & (w_count != 2'd0);
  assign bus.ID_INST   = w_head.inst;
  assign bus.ID_PC     = w_head.pc;
  assign bus.FETCH_ERR = r_err;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random traffic
// checked every cycle against a queue-based reference model.
module tb_fetch_ctrl;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fetch_if bus ();

  fetch_ctrl #(.RESET_PC(RPC), .BUF_DEPTH(2)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0: memf = 32'h0050_0093;
      32'h4: memf = 32'h00A0_0113;
      32'h8: memf = 32'h0020_81B3;
      default: memf = {a[15:0] ^ 16'hA5C3, a[31:16] + 16'h1357};
    endcase
  endfunction

  assign bus.IMEM_INST = memf(bus.IMEM_PC);

  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  logic        m_err;
  logic        m_halt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic rd,
                      input logic [31:0] rpc, input logic rdy);
    bit pop;
    bit push;
    RESET = rst;
    bus.REDIRECT = rd;
    bus.REDIRECT_PC = rpc;
    bus.ID_READY = rdy;
    @(posedge CLK);
    if (rst) begin
      m_q.delete();
      m_pc = RPC;
      m_err = 1'b0;
      m_halt = 1'b0;
    end else if (!m_halt) begin
      if (rd) begin
        m_q.delete();
        if (rpc[1:0] == 2'b00) m_pc = rpc;
        else begin
          m_err = 1'b1;
          m_halt = 1'b1;
        end
      end else begin
        pop = (m_q.size() > 0) && rdy;
        push = (m_q.size() < 2) || pop;
        if (pop) void'(m_q.pop_front());
        if (push) begin
          m_q.push_back({m_pc, memf(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    #1;
    chk("imem_pc", bus.IMEM_PC, m_pc);
    chk("id_valid", 32'(bus.ID_VALID), 32'(m_q.size() > 0));
    chk("fetch_err", 32'(bus.FETCH_ERR), 32'(m_err));
    if (m_q.size() > 0) begin
      chk("id_pc", bus.ID_PC, m_q[0][63:32]);
      chk("id_inst", bus.ID_INST, m_q[0][31:0]);
    end
    if (rst) begin
      chk("rst_id_pc", bus.ID_PC, 32'h0);
      chk("rst_id_inst", bus.ID_INST, 32'h0);
    end
  endtask

  initial begin
    bus.REDIRECT = 1'b0;
    bus.REDIRECT_PC = '0;
    bus.ID_READY = 1'b0;
    // reset and in-order streaming
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    repeat (5) step(0, 0, 0, 1);
    // stall until full, then drain
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    chk("stall_pc", bus.IMEM_PC, 32'h8);
    chk("stall_head", bus.ID_PC, 32'h0);
    repeat (4) step(0, 0, 0, 1);
    // redirect while full
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 32'h40, 0);
    chk("redir_valid", 32'(bus.ID_VALID), 32'h0);
    chk("redir_pc", bus.IMEM_PC, 32'h40);
    step(0, 0, 0, 1);
    chk("redir_head", bus.ID_PC, 32'h40);
    repeat (2) step(0, 0, 0, 1);
    // misaligned redirect halts until reset
    step(0, 1, 32'h42, 1);
    repeat (2) step(0, 0, 0, 1);
    step(0, 1, 32'h80, 1);
    repeat (2) step(0, 0, 0, 1);
    chk("halt_err", 32'(bus.FETCH_ERR), 32'h1);
    step(1, 0, 0, 1);
    // PC wrap at the top of the address space
    step(0, 1, 32'hFFFF_FFF8, 1);
    repeat (4) step(0, 0, 0, 1);
    // reset beats a same-cycle redirect with a full buffer
    repeat (3) step(0, 0, 0, 0);
    step(1, 1, 32'h40, 0);
    chk("rst_redir_pc", bus.IMEM_PC, RPC);
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic rs;
      logic rd;
      logic [31:0] t;
      rs = ($urandom_range(0, 39) == 0);
      rd = ($urandom_range(0, 9) == 0);
      t = $urandom;
      if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
      step(rs, rd, t, 1'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
